reg_scoreboard: RTL

Register-dependency scoreboard that sits on the valid/ready handshake between decode and register access. It tracks outstanding writes to the GPR, segment and MMX register files and stalls any instruction whose source or destination registers have unretired writes. The scheduler issues an instruction only when its operands are safe to read, and it counts pending writes until writeback retires them.

---
 rtl/reg_scoreboard.sv | 87 ++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: counts unretired writes per GPR/segment/MMX register
// and stalls decode->register-access handshake on RAW/WAW or counter-full hazards (0-cycle latency).
module reg_scoreboard #(
    parameter int NREG = 22,
    parameter int CW   = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [NREG-1:0] i_in_src_mask,
    input  logic [NREG-1:0] i_in_dst_mask,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    input  logic            i_wb_reg_en,
    input  logic [2:0]      i_wb_reg_number,
    input  logic            i_wb_stack_en,
    input  logic            i_wb_seg_en,
    input  logic [2:0]      i_wb_seg_number,
    input  logic            i_wb_mmx_en,
    input  logic [2:0]      i_wb_mmx_number,
    output logic            o_hazard,
    output logic [NREG-1:0] o_pending_mask,
    output logic            o_busy,
    output logic            o_underflow_err
);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0]   r_cnt [NREG];
    logic            r_underflow_err;

    logic [NREG-1:0] w_full;
    logic            w_hazard;
    logic            w_issue;
    logic [CW:0]     w_sum  [NREG];
    logic [CW:0]     w_dec  [NREG];
    logic [CW:0]     w_diff [NREG];
    logic [CW-1:0]   w_next [NREG];
    logic [NREG-1:0] w_uf;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            o_pending_mask[i] = (r_cnt[i] != '0);
            w_full[i]         = (r_cnt[i] == CNT_MAX);
        end
    end

    // Flush also raises hazard so nothing issues in the cycle the counters are wiped.
    assign w_hazard    = i_in_valid &
                         ((|((i_in_src_mask | i_in_dst_mask) & o_pending_mask)) |
                          (|(i_in_dst_mask & w_full)) | i_flush);
    assign o_hazard    = w_hazard;
    assign o_in_ready  = i_out_ready & ~w_hazard;
    assign o_out_valid = i_in_valid & ~w_hazard;
    assign w_issue     = i_in_valid & o_in_ready;
    assign o_busy      = |o_pending_mask;
    assign o_underflow_err = r_underflow_err;

    // Retire sources can hit the same register (ESP via GPR port and stack port), so they are summed.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_dec[i]  = {{CW{1'b0}}, (i_wb_reg_en && i < 8 && i_wb_reg_number == i[2:0])}
                      + {{CW{1'b0}}, (i_wb_stack_en && i == 4)}
                      + {{CW{1'b0}}, (i_wb_seg_en && i >= 8 && i < 14 &&
                                      i_wb_seg_number == 3'(i - 8))}
                      + {{CW{1'b0}}, (i_wb_mmx_en && i >= 14 && i < 22 &&
                                      i_wb_mmx_number == 3'(i - 14))};
            w_sum[i]  = {1'b0, r_cnt[i]} + {{CW{1'b0}}, (i_in_dst_mask[i] & w_issue)};
            w_uf[i]   = (w_sum[i] < w_dec[i]);
            w_diff[i] = w_sum[i] - w_dec[i];
            w_next[i] = w_uf[i] ? '0 : w_diff[i][CW-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
            r_underflow_err <= 1'b0;
        end else if (i_flush) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= w_next[i];
            r_underflow_err <= r_underflow_err | (|w_uf);
        end
    end
endmodule
